// File: rtl/branch_predictor.sv
// branch_predictor: bimodal direction predictor built from a table of 2-bit
// saturating counters, with a registered prediction port, an update port
// driven by the execute stage, and branch/mispredict statistics.
//
// Ports:
//   clk, rst          - clock; synchronous active-high reset
//   pred_valid/pc     - prediction request (one per cycle)
//   pred_resp/taken   - registered prediction, valid one cycle after request
//   upd_valid/pc      - resolved-branch update strobe and branch PC
//   upd_br_en         - actual outcome (1 = taken)
//   upd_pred_taken    - prediction that was used for the resolved branch
//   mispredict        - one-cycle pulse after a mispredicted update
//   branch_count      - saturating count of accepted updates
//   mispredict_count  - saturating count of accepted mispredicted updates
module branch_predictor #(
  parameter int unsigned IDX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pred_valid,
  input  logic [31:0] pred_pc,
  output logic        pred_resp,
  output logic        pred_taken,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_br_en,
  input  logic        upd_pred_taken,
  output logic        mispredict,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int unsigned ENTRIES  = 32'(1) << IDX_BITS;
  localparam logic [1:0]  CTR_WNT  = 2'b01;
  localparam logic [1:0]  CTR_MAX  = 2'b11;
  localparam logic [1:0]  CTR_MIN  = 2'b00;
  localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

  logic [1:0]          pht [ENTRIES];
  logic [IDX_BITS-1:0] pred_idx_c;
  logic [IDX_BITS-1:0] upd_idx_c;
  logic [1:0]          upd_cur_c;
  logic [1:0]          upd_next_c;
  logic [1:0]          pred_ctr_c;
  logic                mis_c;
  logic                unused_pc_bits;

  // Word-aligned PC bits select the table entry; the rest alias freely.
  assign pred_idx_c = pred_pc[IDX_BITS+1:2];
  assign upd_idx_c  = upd_pc[IDX_BITS+1:2];
  assign unused_pc_bits = ^{pred_pc[31:IDX_BITS+2], pred_pc[1:0],
                            upd_pc[31:IDX_BITS+2], upd_pc[1:0]};

  assign mis_c = upd_valid && (upd_br_en != upd_pred_taken);

  // Next counter value for the updated entry, and the prediction source with
  // same-index bypass so a request sees the update landing this cycle.
  always_comb begin
    upd_cur_c  = pht[upd_idx_c];
    upd_next_c = upd_cur_c;
    if (upd_br_en) begin
      if (upd_cur_c != CTR_MAX) upd_next_c = upd_cur_c + 2'd1;
    end else begin
      if (upd_cur_c != CTR_MIN) upd_next_c = upd_cur_c - 2'd1;
    end

    pred_ctr_c = pht[pred_idx_c];
    if (upd_valid && (upd_idx_c == pred_idx_c)) pred_ctr_c = upd_next_c;
  end

  // Pattern history table storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        pht[IDX_BITS'(i)] <= CTR_WNT;
      end
    end else if (upd_valid) begin
      pht[upd_idx_c] <= upd_next_c;
    end
  end

  // Registered prediction response.
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_resp  <= 1'b0;
      pred_taken <= 1'b0;
    end else begin
      pred_resp  <= pred_valid;
      pred_taken <= pred_valid && pred_ctr_c[1];
    end
  end

  // Mispredict pulse and saturating statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict       <= 1'b0;
      branch_count     <= 32'd0;
      mispredict_count <= 32'd0;
    end else begin
      mispredict <= mis_c;
      if (upd_valid && (branch_count != STAT_MAX)) begin
        branch_count <= branch_count + 32'd1;
      end
      if (mis_c && (mispredict_count != STAT_MAX)) begin
        mispredict_count <= mispredict_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: table-driven directed test of branch_predictor
// (IDX_BITS=4), plus a hand-written sweep that saturates every entry, resets,
// and confirms every entry returns to weak-not-taken.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_resp;
  logic        pred_taken;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_br_en;
  logic        upd_pred_taken;
  logic        mispredict;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int errors = 0;
  int checks = 0;

  branch_predictor #(.IDX_BITS(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .pred_valid       (pred_valid),
    .pred_pc          (pred_pc),
    .pred_resp        (pred_resp),
    .pred_taken       (pred_taken),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_br_en        (upd_br_en),
    .upd_pred_taken   (upd_pred_taken),
    .mispredict       (mispredict),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        pv;
    logic [31:0] ppc;
    logic        uv;
    logic [31:0] upc;
    logic        ben;
    logic        upt;
    logic        e_resp;
    logic        e_taken;
    logic        e_mis;
    logic [31:0] e_bc;
    logic [31:0] e_mc;
  } vec_t;

  localparam int NV = 28;
  vec_t tv [NV];

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  // Drive one cycle of inputs away from the edge, then settle past the edge.
  task automatic drive(input logic r, input logic pv, input logic [31:0] ppc,
                       input logic uv, input logic [31:0] upc,
                       input logic ben, input logic upt);
    @(negedge clk);
    rst            = r;
    pred_valid     = pv;
    pred_pc        = ppc;
    upd_valid      = uv;
    upd_pc         = upc;
    upd_br_en      = ben;
    upd_pred_taken = upt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //         rst pv ppc            uv upc            ben upt  resp tkn mis bc  mc
    tv[0]  = '{1, 1, 32'h40,         1, 32'h40,         1,  0,   0,   0,  0,  0,  0};
    tv[1]  = '{0, 1, 32'h40,         0, 32'h0,          0,  0,   1,   0,  0,  0,  0};
    tv[2]  = '{0, 0, 32'h0,          1, 32'h40,         1,  0,   0,   0,  1,  1,  1};
    tv[3]  = '{0, 0, 32'h0,          1, 32'h40,         1,  1,   0,   0,  0,  2,  1};
    tv[4]  = '{0, 1, 32'h40,         0, 32'h0,          0,  0,   1,   1,  0,  2,  1};
    tv[5]  = '{0, 1, 32'h80,         0, 32'h0,          0,  0,   1,   1,  0,  2,  1};
    tv[6]  = '{0, 0, 32'h0,          1, 32'h40,         1,  1,   0,   0,  0,  3,  1};
    tv[7]  = '{0, 0, 32'h0,          1, 32'h40,         1,  1,   0,   0,  0,  4,  1};
    tv[8]  = '{0, 0, 32'h0,          1, 32'h40,         1,  1,   0,   0,  0,  5,  1};
    tv[9]  = '{0, 0, 32'h0,          1, 32'h40,         0,  1,   0,   0,  1,  6,  2};
    tv[10] = '{0, 0, 32'h0,          1, 32'h40,         0,  0,   0,   0,  0,  7,  2};
    tv[11] = '{0, 0, 32'h0,          1, 32'h40,         0,  0,   0,   0,  0,  8,  2};
    tv[12] = '{0, 0, 32'h0,          1, 32'h40,         0,  0,   0,   0,  0,  9,  2};
    tv[13] = '{0, 1, 32'h40,         0, 32'h0,          0,  0,   1,   0,  0,  9,  2};
    tv[14] = '{0, 1, 32'h40,         1, 32'h42,         1,  0,   1,   0,  1, 10,  3};
    tv[15] = '{0, 1, 32'h40,         1, 32'hFFFF_0043,  1,  0,   1,   1,  1, 11,  4};
    tv[16] = '{0, 1, 32'h44,         1, 32'h44,         1,  1,   1,   1,  0, 12,  4};
    tv[17] = '{0, 1, 32'h48,         1, 32'h44,         0,  1,   1,   0,  1, 13,  5};
    tv[18] = '{1, 1, 32'h40,         1, 32'h40,         1,  0,   0,   0,  0,  0,  0};
    tv[19] = '{0, 1, 32'h40,         0, 32'h0,          0,  0,   1,   0,  0,  0,  0};
    tv[20] = '{0, 1, 32'h44,         0, 32'h0,          0,  0,   1,   0,  0,  0,  0};
    tv[21] = '{0, 0, 32'h0,          1, 32'h4C,         1,  0,   0,   0,  1,  1,  1};
    tv[22] = '{0, 0, 32'h0,          1, 32'h4C,         0,  0,   0,   0,  0,  2,  1};
    tv[23] = '{0, 0, 32'h0,          1, 32'h4C,         1,  0,   0,   0,  1,  3,  2};
    tv[24] = '{0, 0, 32'h0,          1, 32'h4C,         1,  0,   0,   0,  1,  4,  3};
    tv[25] = '{0, 0, 32'h0,          1, 32'h4C,         0,  0,   0,   0,  0,  5,  3};
    tv[26] = '{0, 0, 32'h0,          0, 32'h0,          0,  0,   0,   0,  0,  5,  3};
    tv[27] = '{0, 1, 32'h4C,         0, 32'h0,          0,  0,   1,   1,  0,  5,  3};

    rst = 1'b1; pred_valid = 1'b0; pred_pc = 32'h0; upd_valid = 1'b0;
    upd_pc = 32'h0; upd_br_en = 1'b0; upd_pred_taken = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      drive(tv[i].rst, tv[i].pv, tv[i].ppc, tv[i].uv, tv[i].upc, tv[i].ben, tv[i].upt);
      chk("pred_resp", i, 32'(pred_resp), 32'(tv[i].e_resp));
      if (tv[i].e_resp) chk("pred_taken", i, 32'(pred_taken), 32'(tv[i].e_taken));
      chk("mispredict", i, 32'(mispredict), 32'(tv[i].e_mis));
      chk("branch_count", i, branch_count, tv[i].e_bc);
      chk("mispredict_count", i, mispredict_count, tv[i].e_mc);
    end

    // Drive every entry to strong-taken with back-to-back updates.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1, 32'(i * 4), 1'b1, 1'b1);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 32'(i * 4), 1'b1, 1'b1);
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 32'(i * 4), 1'b0, 32'h0, 1'b0, 1'b0);
      chk("sweep_taken", 100 + i, 32'(pred_taken), 32'd1);
    end
    chk("sweep_bc", 116, branch_count, 32'd37);

    // Reset with both ports active; all entries must read weak-not-taken.
    drive(1'b1, 1'b1, 32'h8, 1'b1, 32'h8, 1'b1, 1'b0);
    chk("rst_resp", 200, 32'(pred_resp), 32'd0);
    chk("rst_bc", 200, branch_count, 32'd0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 32'(i * 4), 1'b0, 32'h0, 1'b0, 1'b0);
      chk("post_rst_resp", 201 + i, 32'(pred_resp), 32'd1);
      chk("post_rst_taken", 201 + i, 32'(pred_taken), 32'd0);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("idle_resp", 300, 32'(pred_resp), 32'd0);
    chk("idle_mc", 300, mispredict_count, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL provide parameter IDX_BITS, default 4, meaning log2 of the pattern history table (PHT) entry count.
REQ-002 SHALL have port clk  input  1  system clock, all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port pred_valid  input  1  prediction request strobe, one request per cycle.
REQ-005 SHALL have port pred_pc  input  32  PC of the branch being fetched.
REQ-006 SHALL have port pred_resp  output  1  prediction result valid, one cycle after the request.
REQ-007 SHALL have port pred_taken  output  1  predicted direction, meaningful only when pred_resp=1.
REQ-008 SHALL have port upd_valid  input  1  resolved-branch strobe from execute.
REQ-009 SHALL have port upd_pc  input  32  PC of the resolved branch.
REQ-010 SHALL have port upd_br_en  input  1  actual outcome from the branch comparator (1=taken).
REQ-011 SHALL have port upd_pred_taken  input  1  prediction that was used for that branch.
REQ-012 SHALL have port mispredict  output  1  registered pulse: last update disagreed with its prediction.
REQ-013 SHALL have port branch_count  output  32  number of accepted updates.
REQ-014 SHALL have port mispredict_count  output  32  number of accepted mispredicted updates.

Function
REQ-015 SHALL hold 2**IDX_BITS 2-bit saturating counters: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-016 SHALL index the PHT with pc[IDX_BITS+1:2] for both ports; pc[1:0] and upper bits ignored.
REQ-017 SHALL register prediction: pred_valid at edge N -> pred_resp=1 and pred_taken=counter[1] during cycle N+1; pred_resp=0 otherwise.
REQ-018 SHALL apply update at the edge where upd_valid=1: upd_br_en=1 increments the counter, saturating at 11; upd_br_en=0 decrements, saturating at 00.
REQ-019 SHALL, when pred_valid and upd_valid hit the same index in the same cycle, return the post-update counter value (bypass).
REQ-020 SHALL, when they hit different indices in the same cycle, serve both with no stall and no interaction.
REQ-021 SHALL assert mispredict for exactly one cycle after an update with upd_br_en != upd_pred_taken; 0 otherwise.
REQ-022 SHALL increment branch_count by 1 per update and mispredict_count by 1 per mispredicted update, in the cycle after the update.
REQ-023 SHALL saturate both statistics counters at 32'hFFFF_FFFF (no wrap).
REQ-024 SHALL accept back-to-back updates every cycle, including consecutive updates to the same index (each uses the prior update's result).
REQ-025 SHALL have no internal back-pressure; there are no ready outputs and both ports always accept.

Reset
REQ-026 SHALL, when rst=1 at an edge, set every PHT counter to 01 (weak-NT).
REQ-027 SHALL, when rst=1 at an edge, drive pred_resp=0, pred_taken=0, mispredict=0, branch_count=0 and mispredict_count=0 in the following cycle.
REQ-028 SHALL give rst priority over pred_valid/upd_valid in the same cycle; those requests are dropped and do not update state.
REQ-029 SHALL, with rst asserted mid-operation, discard any prediction response pending from the previous cycle.

Verification
REQ-030 SHALL pass: reset, predict pc=0x0000_0040 -> next cycle pred_resp=1, pred_taken=0.
REQ-031 SHALL pass: 2 updates pc=0x40 upd_br_en=1, then predict 0x40 -> pred_taken=1; 3 more taken updates, then 3 not-taken -> counter 00, pred_taken=0.
REQ-032 SHALL pass: same cycle upd pc=0x44 br_en=1 (counter 01->10) and predict pc=0x44 -> pred_taken=1 (bypass); pred pc=0x48 same cycle -> pred_taken=0.
REQ-033 SHALL pass: 5 updates with upd_pred_taken=0, upd_br_en=1,0,1,1,0 -> mispredict pulses 1,0,1,1,0; branch_count=5, mispredict_count=3.
REQ-034 SHALL pass: aliasing, update pc=0x40 taken twice, then predict pc=0x80 (IDX_BITS=4) -> pred_taken=1.
REQ-035 SHALL pass: rst asserted while pred_valid=1 and upd_valid=1 -> next cycle pred_resp=0, counts 0, all counters back to 01.
